// File: rtl/uart_wb_master.sv
// uart_wb_master: polls a MiniUART over WISHBONE and bridges its data register
// to valid/ready byte streams. Define UART_WBM_IRQ_EN to gate polling on rx_irq.
module uart_wb_master #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLDOFF     = 3,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic        CLK_I,
    input  logic        RST_N_I,
    output logic [2:0]  ADR_O,
    output logic [31:0] DAT_O,
    input  logic [31:0] DAT_I,
    output logic        STB_O,
    output logic        WE_O,
    input  logic        ACK_I,
    input  logic        rx_irq,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        bus_err
);

    localparam logic [2:0] OFF_UART_DATA = 3'd0;
    localparam logic [2:0] OFF_UART_LSR  = 3'd5;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int HW = $clog2(HOLDOFF + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_RD,
        S_WR,
        S_HOLD
    } state_t;

    state_t state;

    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wr;
    logic [AW-1:0] tx_rd;
    logic [CW-1:0] tx_cnt;
    logic          tx_full;
    logic          tx_empty;
    logic          tx_push;
    logic          tx_pop;

    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wr;
    logic [AW-1:0] rx_rd;
    logic [CW-1:0] rx_cnt;
    logic          rx_full;
    logic          rx_push;
    logic          rx_pop;

    logic [TW-1:0] tmo_cnt;
    logic [HW-1:0] hold_cnt;
    logic          last_rx;
    logic          rx_ok;
    logic          tx_ok;
    logic          tmo_hit;
    logic          idle_go;

    assign tx_full  = (tx_cnt == CW'(FIFO_DEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign tx_ready = !tx_full;
    assign tx_push  = tx_valid && !tx_full;
    assign tx_pop   = (state == S_WR) && STB_O && ACK_I;

    assign rx_full  = (rx_cnt == CW'(FIFO_DEPTH));
    assign rx_valid = (rx_cnt != '0);
    assign rx_data  = rx_mem[rx_rd];
    assign rx_pop   = rx_valid && rx_ready;
    assign rx_push  = (state == S_RD) && STB_O && ACK_I;

    // LSR bit0 = byte received, bit5 = transmitter idle
    assign rx_ok   = DAT_I[0] && !rx_full;
    assign tx_ok   = DAT_I[5] && !tx_empty;
    assign tmo_hit = (tmo_cnt == TW'(ACK_TIMEOUT - 1));

`ifdef UART_WBM_IRQ_EN
    assign idle_go = rx_irq || !tx_empty;
`else
    assign idle_go = 1'b1;
`endif

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) tx_mem[i] <= '0;
        end else begin
            if (tx_push) begin
                tx_mem[tx_wr] <= tx_data;
                tx_wr         <= tx_wr + AW'(1);
            end
            if (tx_pop) tx_rd <= tx_rd + AW'(1);
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
        end
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) rx_mem[i] <= '0;
        end else begin
            if (rx_push) begin
                rx_mem[rx_wr] <= DAT_I[7:0];
                rx_wr         <= rx_wr + AW'(1);
            end
            if (rx_pop) rx_rd <= rx_rd + AW'(1);
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
        end
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state    <= S_IDLE;
            STB_O    <= 1'b0;
            WE_O     <= 1'b0;
            ADR_O    <= '0;
            DAT_O    <= '0;
            tmo_cnt  <= '0;
            hold_cnt <= '0;
            last_rx  <= 1'b0;
            bus_err  <= 1'b0;
        end else if (STB_O && !ACK_I) begin
            // stalled access: abort after ACK_TIMEOUT cycles without ACK
            if (tmo_hit) begin
                state    <= S_HOLD;
                STB_O    <= 1'b0;
                WE_O     <= 1'b0;
                ADR_O    <= '0;
                DAT_O    <= '0;
                tmo_cnt  <= '0;
                hold_cnt <= '0;
                bus_err  <= 1'b1;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end else begin
            tmo_cnt <= '0;
            unique case (state)
                S_IDLE: begin
                    if (idle_go) begin
                        state <= S_POLL;
                        STB_O <= 1'b1;
                        WE_O  <= 1'b0;
                        ADR_O <= OFF_UART_LSR;
                    end
                end
                S_POLL: begin
                    if (rx_ok && (!tx_ok || !last_rx)) begin
                        state <= S_RD;
                        ADR_O <= OFF_UART_DATA;
                    end else if (tx_ok) begin
                        state <= S_WR;
                        WE_O  <= 1'b1;
                        ADR_O <= OFF_UART_DATA;
                        DAT_O <= {24'b0, tx_mem[tx_rd]};
                    end else begin
                        state <= S_IDLE;
                        STB_O <= 1'b0;
                        ADR_O <= '0;
                    end
                end
                S_RD, S_WR: begin
                    state    <= S_HOLD;
                    STB_O    <= 1'b0;
                    WE_O     <= 1'b0;
                    ADR_O    <= '0;
                    DAT_O    <= '0;
                    hold_cnt <= '0;
                    last_rx  <= (state == S_RD);
                end
                S_HOLD: begin
                    if (hold_cnt == HW'(HOLDOFF - 1)) begin
                        state <= S_POLL;
                        STB_O <= 1'b1;
                        WE_O  <= 1'b0;
                        ADR_O <= OFF_UART_LSR;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    STB_O <= 1'b0;
                    WE_O  <= 1'b0;
                    ADR_O <= '0;
                    DAT_O <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wb_master.sv
// tb_uart_wb_master: directed checks of uart_wb_master against a small
// MiniUART register model with a zero-wait slave and optional WR stall.
`timescale 1ns/1ps
module tb_uart_wb_master;

    localparam logic [2:0] A_DATA = 3'd0;
    localparam logic [2:0] A_LSR  = 3'd5;

    logic        CLK_I = 1'b0;
    logic        RST_N_I = 1'b0;
    logic [2:0]  ADR_O;
    logic [31:0] DAT_O;
    logic [31:0] DAT_I;
    logic        STB_O;
    logic        WE_O;
    logic        ACK_I;
    logic        rx_irq = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        bus_err;

    int n_chk = 0;
    int n_fail = 0;

    // UART model state
    logic       ts = 1'b0;
    logic       wr_block = 1'b0;
    int         rx_total = 0;
    logic [7:0] rx_tab [8];

    // monitor state
    int         cyc = 0;
    int         rd_idx = 0;
    int         n_rd = 0;
    int         n_wr = 0;
    int         stall = 0;
    int         rd_edge = 0;
    int         gap = 0;
    logic       rd_seen = 1'b0;
    int         order_q[$];
    logic [7:0] wr_q[$];

    logic rs;
    assign rs = (rd_idx < rx_total);
    assign DAT_I = (ADR_O == A_LSR) ? {26'b0, ts, 4'b0, rs}
                                    : {24'b0, rx_tab[rd_idx[2:0]]};
    assign ACK_I = STB_O && !(WE_O && wr_block);

    uart_wb_master dut (
        .CLK_I    (CLK_I),
        .RST_N_I  (RST_N_I),
        .ADR_O    (ADR_O),
        .DAT_O    (DAT_O),
        .DAT_I    (DAT_I),
        .STB_O    (STB_O),
        .WE_O     (WE_O),
        .ACK_I    (ACK_I),
        .rx_irq   (rx_irq),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .bus_err  (bus_err)
    );

    always #5 CLK_I = ~CLK_I;

    always @(posedge CLK_I) begin
        cyc <= cyc + 1;
        if (!RST_N_I) begin
            rd_idx  <= 0;
            n_rd    <= 0;
            n_wr    <= 0;
            stall   <= 0;
            rd_seen <= 1'b0;
            gap     <= 0;
            order_q.delete();
            wr_q.delete();
        end else begin
            if (STB_O && WE_O && !ACK_I) stall <= stall + 1;
            if (STB_O && ACK_I && ADR_O == A_DATA && !WE_O) begin
                n_rd    <= n_rd + 1;
                rd_idx  <= rd_idx + 1;
                rd_edge <= cyc;
                rd_seen <= 1'b1;
                order_q.push_back(1);
            end
            if (STB_O && ACK_I && ADR_O == A_DATA && WE_O) begin
                n_wr <= n_wr + 1;
                order_q.push_back(2);
                wr_q.push_back(DAT_O[7:0]);
            end
            if (STB_O && ACK_I && ADR_O == A_LSR && rd_seen) begin
                gap     <= cyc - rd_edge;
                rd_seen <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK_I);
        RST_N_I = 1'b0;
        repeat (2) @(negedge CLK_I);
        RST_N_I = 1'b1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK_I);
    endtask

    task automatic push(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge CLK_I);
        tx_valid = 1'b0;
    endtask

    task automatic pop();
        rx_ready = 1'b1;
        @(negedge CLK_I);
        rx_ready = 1'b0;
    endtask

    initial begin
        int k;
        int hi;
        for (int i = 0; i < 8; i++) rx_tab[i] = 8'h00;

        // reset values
        RST_N_I = 1'b0;
        tick(2);
        chk("rst_stb", STB_O, 0);
        chk("rst_we", WE_O, 0);
        chk("rst_adr", ADR_O, 0);
        chk("rst_dat", DAT_O, 0);
        chk("rst_txrdy", tx_ready, 1);
        chk("rst_rxvld", rx_valid, 0);
        chk("rst_rxdat", rx_data, 0);
        chk("rst_berr", bus_err, 0);

        // single TX byte, pushed while IDLE
        ts = 1'b1;
        rx_total = 0;
        do_reset();
        for (k = 0; k < 10 && STB_O !== 1'b0; k++) tick(1);
        chk("tx_sync", STB_O, 0);
        push(8'h41);
        chk("tx_poll_stb", STB_O, 1);
        chk("tx_poll_adr", ADR_O, A_LSR);
        chk("tx_poll_we", WE_O, 0);
        tick(1);
        chk("tx_wr_we", WE_O, 1);
        chk("tx_wr_adr", ADR_O, A_DATA);
        chk("tx_wr_dat", DAT_O, 32'h41);
        tick(1);
        chk("tx_after_stb", STB_O, 0);
        tick(30);
        chk("tx_one_wr", n_wr, 1);
        chk("tx_rdy", tx_ready, 1);

        // single RX byte and HOLDOFF gap
        ts = 1'b0;
        rx_tab[0] = 8'h5A;
        rx_total = 1;
        do_reset();
        for (k = 0; k < 40 && !rx_valid; k++) tick(1);
        chk("rx_vld", rx_valid, 1);
        chk("rx_dat", rx_data, 8'h5A);
        tick(10);
        chk("rx_gap", gap, 4);
        chk("rx_one_rd", n_rd, 1);
        pop();
        chk("rx_popped", rx_valid, 0);

        // TX FIFO full: fifth push refused
        ts = 1'b0;
        rx_total = 0;
        do_reset();
        for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
        chk("full_rdy", tx_ready, 0);
        ts = 1'b1;
        tick(60);
        chk("full_nwr", n_wr, 4);
        chk("full_first", wr_q.size() > 0 ? wr_q[0] : 8'hxx, 8'hC0);
        chk("full_last", wr_q.size() > 3 ? wr_q[3] : 8'hxx, 8'hC3);

        // both eligible: RD, WR alternate
        ts = 1'b0;
        rx_total = 0;
        do_reset();
        push(8'h10);
        push(8'h11);
        rx_tab[0] = 8'hA0;
        rx_tab[1] = 8'hA1;
        rx_total = 2;
        ts = 1'b1;
        tick(60);
        chk("alt_n", order_q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("alt_kind", i < order_q.size() ? order_q[i] : -1,
                (i % 2 == 0) ? 1 : 2);
        chk("alt_wr0", wr_q.size() > 0 ? wr_q[0] : 8'hxx, 8'h10);
        chk("alt_wr1", wr_q.size() > 1 ? wr_q[1] : 8'hxx, 8'h11);
        chk("alt_rx0", rx_data, 8'hA0);
        pop();
        chk("alt_rx1", rx_data, 8'hA1);
        pop();
        chk("alt_empty", rx_valid, 0);

        // RX FIFO full blocks RD until one pop
        ts = 1'b0;
        for (int i = 0; i < 6; i++) rx_tab[i] = 8'hB0 + 8'(i);
        rx_total = 6;
        do_reset();
        tick(60);
        chk("rxf_nrd", n_rd, 4);
        chk("rxf_head", rx_data, 8'hB0);
        pop();
        tick(40);
        chk("rxf_nrd2", n_rd, 5);
        for (int i = 0; i < 4; i++) begin
            chk("rxf_order", rx_data, 8'hB1 + 8'(i));
            pop();
        end

        // WR never ACKed: timeout, bus_err, retry
        ts = 1'b1;
        rx_total = 0;
        wr_block = 1'b1;
        do_reset();
        push(8'h77);
        for (k = 0; k < 100 && !bus_err; k++) tick(1);
        chk("tmo_berr", bus_err, 1);
        chk("tmo_stall", stall, 8);
        chk("tmo_stb", STB_O, 0);
        chk("tmo_nwr", n_wr, 0);
        wr_block = 1'b0;
        tick(20);
        chk("tmo_retry_n", n_wr, 1);
        chk("tmo_retry_d", wr_q.size() > 0 ? wr_q[0] : 8'hxx, 8'h77);
        chk("tmo_sticky", bus_err, 1);

        // polling activity with no work
        ts = 1'b0;
        rx_total = 0;
        rx_irq = 1'b0;
        do_reset();
        hi = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (STB_O) hi++;
        end
`ifdef UART_WBM_IRQ_EN
        chk("irq_quiet", hi, 0);
        rx_irq = 1'b1;
        tick(1);
        chk("irq_poll_stb", STB_O, 1);
        chk("irq_poll_adr", ADR_O, A_LSR);
        rx_irq = 1'b0;
`else
        chk("poll_rate", hi, 25);
`endif

        // reset mid-access drops STB_O at once
        for (k = 0; k < 10 && STB_O !== 1'b1; k++) tick(1);
        chk("mid_stb_up", STB_O, 1);
        #2 RST_N_I = 1'b0;
        #1 chk("mid_stb_drop", STB_O, 0);
        tick(2);
        RST_N_I = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
